// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage state encoding and instruction constants shared by the fetch sequencer.
package cpu_pkg;
    typedef enum logic [2:0] {BOOT, RUN, HOLD, REDIR, DBG} fetch_state_e;
    localparam int INSN_BYTES = 4;
    localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/imem_port_arb.sv
// imem_port_arb: steers the single instruction-memory read port between fetch and debug,
// and registers the debug read data and acknowledge.
module imem_port_arb #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_sel,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata
);
    logic        ack_q;
    logic [31:0] rdata_q;

    assign imem_addr = dbg_sel ? dbg_addr : fetch_addr;
    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ack_q <= dbg_sel;
            if (dbg_sel) rdata_q <= imem_rdata;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register, next-PC selection, redirect flush/bubbles and the fetch FSM,
// lending the instruction-memory port to debug reads while fetch is stalled.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                REDIRECT_BUB = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IFWrite,
    input  logic              Branch,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpAddr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       Instruction_if,
    output logic              instr_valid,
    output logic              IF_flush,
    output logic              misalign,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata
);
    localparam logic [1:0] BUB_INIT = 2'(REDIRECT_BUB - 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, pend_tgt_q, tgt;
    logic [31:0]       inst_q;
    logic [1:0]        bub_q;
    logic              pend_q, live, redir;

    // Both redirect kinds share JumpAddr; a redirect latched during DBG replays afterwards.
    always_comb begin
        live  = Jump | Branch;
        tgt   = live ? JumpAddr : pend_tgt_q;
        redir = (live | pend_q) & (state_q == RUN || state_q == HOLD || state_q == REDIR);
    end

    assign PC             = pc_q;
    assign IF_flush       = state_q == BOOT || redir;
    assign misalign       = redir & |tgt[1:0];
    assign instr_valid    = state_q == RUN || state_q == HOLD;
    assign Instruction_if = state_q == RUN ? imem_rdata :
                            (state_q == HOLD || state_q == DBG) ? inst_q : NOP;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            bub_q      <= 2'd0;
            inst_q     <= NOP;
        end else begin
            pend_q <= state_q == DBG && live;
            if (state_q == DBG && live) pend_tgt_q <= JumpAddr;
            if (state_q == RUN) inst_q <= imem_rdata;
            if (redir) begin
                pc_q    <= {tgt[ADDR_W-1:2], 2'b00};
                bub_q   <= BUB_INIT;
                state_q <= REDIR;
            end else begin
                case (state_q)
                    BOOT: state_q <= RUN;
                    RUN: begin
                        if (IFWrite) pc_q <= pc_q + ADDR_W'(INSN_BYTES);
                        else state_q <= HOLD;
                    end
                    HOLD: begin
                        if (IFWrite) begin
                            pc_q    <= pc_q + ADDR_W'(INSN_BYTES);
                            state_q <= RUN;
                        end else if (dbg_req && !dbg_ack) state_q <= DBG;
                    end
                    REDIR: begin
                        if (bub_q == 2'd0) state_q <= RUN;
                        else bub_q <= bub_q - 2'd1;
                    end
                    DBG: state_q <= IFWrite ? RUN : HOLD;
                    default: state_q <= BOOT;
                endcase
            end
        end
    end

    imem_port_arb #(.ADDR_W(ADDR_W)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .dbg_sel   (state_q == DBG),
        .fetch_addr(pc_q),
        .dbg_addr  (dbg_addr),
        .imem_rdata(imem_rdata),
        .imem_addr (imem_addr),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; stimulus queues redirect targets and debug read data,
// a negedge monitor tracks the architectural fetch stream and checks every presented output.
module tb_fetch_sequencer;
    localparam int AW = 32;
    localparam int BUB = 1;
    localparam logic [AW-1:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic IFWrite = 1'b1, Branch = 1'b0, Jump = 1'b0, dbg_req = 1'b0;
    logic [AW-1:0] JumpAddr = '0, dbg_addr = '0;
    logic [AW-1:0] imem_addr, PC;
    logic [31:0] imem_rdata, Instruction_if, dbg_rdata;
    logic instr_valid, IF_flush, misalign, dbg_ack;

    int passed = 0, total = 0;
    logic [AW-1:0] redir_q[$];
    logic [31:0] dbg_q[$];

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC(RST_PC), .REDIRECT_BUB(BUB)) dut (
        .clk(clk), .reset(reset), .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump),
        .JumpAddr(JumpAddr), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .PC(PC),
        .Instruction_if(Instruction_if), .instr_valid(instr_valid), .IF_flush(IF_flush),
        .misalign(misalign), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = rom(imem_addr);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input logic ifw, input logic br, input logic jp, input logic [AW-1:0] tg);
        @(posedge clk);
        #2;
        if (dbg_req && dbg_ack) dbg_req = 1'b0;
        IFWrite = ifw;
        Branch = br;
        Jump = jp;
        JumpAddr = tg;
        if (br | jp) redir_q.push_back(tg);
    endtask

    task automatic dbg_start(input logic [AW-1:0] a);
        dbg_addr = a;
        dbg_req = 1'b1;
        dbg_q.push_back(rom(a));
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        reset = 1'b0;
        Branch = 1'b0;
        Jump = 1'b0;
        dbg_req = 1'b0;
        IFWrite = 1'b1;
        repeat (n) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_boot();
        int n = 0;
        while (!instr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            total++;
            $display("FAIL boot_timeout: instr_valid still 0 after %0d cycles, expected 1", n);
        end
    endtask

    // Monitor: expected PC is the next instruction the pipeline should accept.
    initial begin
        logic prev_rst, booted, armed, last_ack;
        int bub;
        logic [AW-1:0] exp_pc, t;
        prev_rst = 1'b0; booted = 1'b0; armed = 1'b0; last_ack = 1'b0; bub = 0; exp_pc = RST_PC;
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                check("rst_pc", PC, RST_PC);
                check("rst_flush", IF_flush, 1'b1);
                check("rst_valid", instr_valid, 1'b0);
                check("rst_misalign", misalign, 1'b0);
                check("rst_ack", dbg_ack, 1'b0);
                check("rst_rdata", dbg_rdata, 32'h0);
                redir_q.delete();
                dbg_q.delete();
                booted = 1'b0; armed = 1'b0; last_ack = 1'b0; exp_pc = RST_PC;
            end else begin
                check("ack_double", dbg_ack & last_ack, 1'b0);
                check("misalign_noflush", misalign & ~IF_flush, 1'b0);
                if (dbg_ack) begin
                    if (dbg_q.size() == 0) begin
                        total++;
                        $display("FAIL dbg_ack_spurious: got ack, expected none");
                    end else check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
                end
                last_ack = dbg_ack;
                if (IF_flush) begin
                    if (!booted) check("boot_valid", instr_valid, 1'b0);
                    else if (redir_q.size() == 0) begin
                        total++;
                        $display("FAIL flush_spurious: got IF_flush=1, expected 0");
                    end else begin
                        t = redir_q.pop_front();
                        check("misalign", misalign, |t[1:0]);
                        exp_pc = {t[AW-1:2], 2'b00};
                        armed = 1'b1;
                        bub = 0;
                    end
                end else if (instr_valid) begin
                    if (armed) check("bubbles", bub, BUB);
                    armed = 1'b0;
                    booted = 1'b1;
                    check("pc", PC, exp_pc);
                    check("insn", Instruction_if, rom(exp_pc));
                    if (IFWrite) exp_pc = exp_pc + 4;
                end else if (armed) bub++;
            end
            prev_rst = reset;
        end
    end

    initial begin
        int gap, wait_n;
        gap = 0;
        wait_n = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        wait_boot();
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 32'h40);
        repeat (2) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h83);
        repeat (2) step(1, 0, 0, 0);
        step(1, 1, 0, 32'h20);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        dbg_start(32'h100);
        repeat (3) step(0, 0, 0, 0);
        dbg_start(32'h104);
        step(1, 1, 0, 32'h200);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 32'hFFFF_FFF8);
        repeat (5) step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, ifw;
            logic [1:0] kind;
            logic [AW-1:0] tg;
            ifw = $urandom_range(9, 0) > 3;
            r = gap >= 2 && $urandom_range(11, 0) == 0;
            kind = 2'($urandom_range(3, 1));
            tg = $urandom_range(3, 0) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step(ifw, r & kind[0], r & kind[1], tg);
            gap = r ? 0 : gap + 1;
            if (dbg_req) begin
                wait_n++;
                if (wait_n > 400) begin
                    total++;
                    $display("FAIL dbg_timeout: no dbg_ack after %0d cycles, expected one", wait_n);
                    dbg_req = 1'b0;
                    wait_n = 0;
                end
            end else if ($urandom_range(5, 0) == 0) begin
                dbg_start($urandom);
                wait_n = 0;
            end
        end
        for (int n = 0; n < 50 && dbg_req; n++) step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        dbg_start(32'h300);
        do_reset(2);
        wait_boot();
        repeat (4) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h51);
        repeat (4) step(1, 0, 0, 0);
        check("redir_left", redir_q.size(), 0);
        check("dbg_left", dbg_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
